// File: rtl/ball_controller.sv
`default_nettype none
// ============================================================================
// Module   : ball_controller
// Purpose  : Ball engine for the paddle game. Moves a square ball once per
//            enabled frame, bounces it off the playfield walls and the paddle,
//            tracks score and lives, and draws the ball into the VGA raster.
// Options  : BALL_ANGLE_EN - when defined, a paddle hit far from the paddle
//            centre doubles |dx|; a hit near the centre restores |dx|=STEP.
// Revision : 1.0 - initial release
// ============================================================================
module ball_controller #(
    parameter int          X_MIN       = 144,
    parameter int          X_MAX       = 783,
    parameter int          Y_MIN       = 35,
    parameter int          Y_MAX       = 515,
    parameter int          BALL_HALF   = 4,
    parameter int          PAD_HALF_W  = 25,
    parameter int          PAD_HALF_H  = 5,
    parameter int          STEP        = 2,
    parameter int          FRAME_DIV   = 1,
    parameter int          MISS_FRAMES = 60,
    parameter int          LIVES_INIT  = 3,
    parameter logic [11:0] BALL_RGB    = 12'h00F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic [9:0]  paddle_x,
    input  logic [9:0]  paddle_y,
    input  logic        launch,
    output logic        ball_on,
    output logic [11:0] rgb,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic        game_over
);

    localparam int MC_W = $clog2(MISS_FRAMES + 1);

    // All position arithmetic is 11-bit signed so edge subtraction never wraps.
    localparam logic signed [10:0] C_BH     = 11'(BALL_HALF);
    localparam logic signed [10:0] C_PH     = 11'(PAD_HALF_H);
    localparam logic signed [10:0] C_REACH  = 11'(PAD_HALF_W + BALL_HALF);
    localparam logic signed [10:0] C_XMIN   = 11'(X_MIN);
    localparam logic signed [10:0] C_XMAX   = 11'(X_MAX);
    localparam logic signed [10:0] C_YMIN   = 11'(Y_MIN);
    localparam logic signed [10:0] C_YMAX   = 11'(Y_MAX);
    localparam logic signed [10:0] C_XLO    = 11'(X_MIN + BALL_HALF);
    localparam logic signed [10:0] C_XHI    = 11'(X_MAX - BALL_HALF);
    localparam logic signed [10:0] C_YLO    = 11'(Y_MIN + BALL_HALF);
    localparam logic signed [10:0] C_YHI    = 11'(Y_MAX - BALL_HALF);
    localparam logic signed [3:0]  C_STEP   = 4'(STEP);
    localparam logic [9:0]         C_RST_X  = 10'd463;
    localparam logic [9:0]         C_RST_Y  = 10'(Y_MAX - 40 - PAD_HALF_H - BALL_HALF - 1);
`ifdef BALL_ANGLE_EN
    localparam logic signed [10:0] C_ANG    = 11'(PAD_HALF_W / 2);
    localparam logic signed [3:0]  C_STEP2  = 4'(2 * STEP);
`endif

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_MOVE  = 2'd1,
        ST_MISS  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_strobe;
    logic [3:0]         r_frame_cnt;
    logic [MC_W-1:0]    r_miss_cnt;
    logic [9:0]         r_ball_x;
    logic [9:0]         r_ball_y;
    logic signed [3:0]  r_dx;
    logic signed [3:0]  r_dy;
    logic [7:0]         r_score;
    logic [1:0]         r_lives;
    logic               r_game_over;

    logic               w_update;
    logic signed [10:0] w_bx, w_by, w_px, w_py, w_dx, w_dy, w_pad_top, w_rest_y;
    logic signed [10:0] w_nx, w_ny, w_hd, w_vd;
    logic signed [3:0]  w_ndx, w_ndy;
    logic               w_hit, w_miss, w_on;
    logic [9:0]         w_serve_x;
`ifdef BALL_ANGLE_EN
    logic signed [3:0]  w_mag;
`endif

    function automatic logic signed [10:0] f_clamp(input logic signed [10:0] v,
                                                   input logic signed [10:0] lo,
                                                   input logic signed [10:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    function automatic logic signed [10:0] f_abs(input logic signed [10:0] v);
        return (v < 11'sd0) ? -v : v;
    endfunction

    assign w_bx      = $signed({1'b0, r_ball_x});
    assign w_by      = $signed({1'b0, r_ball_y});
    assign w_px      = $signed({1'b0, paddle_x});
    assign w_py      = $signed({1'b0, paddle_y});
    assign w_dx      = $signed({{7{r_dx[3]}}, r_dx});
    assign w_dy      = $signed({{7{r_dy[3]}}, r_dy});
    assign w_pad_top = w_py - C_PH;
    // Resting height just above the paddle face, used for serve and bounce.
    assign w_rest_y  = f_clamp(w_pad_top - C_BH - 11'sd1, C_YLO, C_YHI);
    assign w_serve_x = 10'(f_clamp(w_px, C_XLO, C_XHI));
    assign w_update  = r_strobe && (r_frame_cnt == 4'(FRAME_DIV - 1));

    // Next position, direction and collision outcome for a MOVE update.
    always_comb begin
        w_nx  = w_bx + w_dx;
        w_ny  = w_by + w_dy;
        w_ndx = r_dx;
        w_ndy = r_dy;
`ifdef BALL_ANGLE_EN
        w_mag = C_STEP;
`endif
        if (w_nx - C_BH <= C_XMIN) begin
            w_ndx = -r_dx;
            w_nx  = C_XLO;
        end else if (w_nx + C_BH >= C_XMAX) begin
            w_ndx = -r_dx;
            w_nx  = C_XHI;
        end
        if (w_ny - C_BH <= C_YMIN) begin
            w_ndy = -r_dy;
            w_ny  = C_YLO;
        end
        // The previous-position test stops a ball already below the face
        // from being scooped back up.
        w_hit = (r_dy > 4'sd0) &&
                (w_ny + C_BH >= w_pad_top) &&
                (w_by + C_BH <  w_pad_top) &&
                (f_abs(w_nx - w_px) <= C_REACH);
        if (w_hit) begin
            w_ndy = -C_STEP;
            w_ny  = w_rest_y;
`ifdef BALL_ANGLE_EN
            w_mag = (f_abs(w_nx - w_px) > C_ANG) ? C_STEP2 : C_STEP;
            w_ndx = w_ndx[3] ? -w_mag : w_mag;
`endif
        end
        w_miss = !w_hit && (w_ny + C_BH >= C_YMAX);
        if (w_miss) begin
            w_ny = C_YHI;
        end
    end

    // Pixel-inside-ball test against the registered centre.
    always_comb begin
        w_hd = $signed({1'b0, hCount}) - w_bx;
        w_vd = $signed({1'b0, vCount}) - w_by;
        w_on = bright && (f_abs(w_hd) <= C_BH) && (f_abs(w_vd) <= C_BH);
    end

    // Frame strobe at raster origin and the update divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe    <= 1'b0;
            r_frame_cnt <= 4'd0;
        end else begin
            r_strobe <= (hCount == 10'd0) && (vCount == 10'd0);
            if (r_strobe) begin
                if (r_frame_cnt == 4'(FRAME_DIV - 1)) r_frame_cnt <= 4'd0;
                else                                  r_frame_cnt <= r_frame_cnt + 4'd1;
            end
        end
    end

    // Game state machine; everything advances only on update cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SERVE;
            r_ball_x    <= C_RST_X;
            r_ball_y    <= C_RST_Y;
            r_dx        <= C_STEP;
            r_dy        <= -C_STEP;
            r_score     <= 8'd0;
            r_lives     <= 2'(LIVES_INIT);
            r_game_over <= 1'b0;
            r_miss_cnt  <= '0;
        end else if (w_update) begin
            case (r_state)
                ST_SERVE: begin
                    r_ball_x <= w_serve_x;
                    r_ball_y <= w_rest_y[9:0];
                    if (launch) begin
                        r_state <= ST_MOVE;
                        r_dx    <= C_STEP;
                        r_dy    <= -C_STEP;
                    end
                end
                ST_MOVE: begin
                    r_ball_x <= w_nx[9:0];
                    r_ball_y <= w_ny[9:0];
                    r_dx     <= w_ndx;
                    r_dy     <= w_ndy;
                    if (w_hit && (r_score != 8'hFF)) r_score <= r_score + 8'd1;
                    if (w_miss) begin
                        r_state    <= ST_MISS;
                        r_miss_cnt <= '0;
                    end
                end
                ST_MISS: begin
                    if (r_miss_cnt == MC_W'(MISS_FRAMES - 1)) begin
                        r_miss_cnt <= '0;
                        if (r_lives == 2'd1) begin
                            r_lives     <= 2'd0;
                            r_game_over <= 1'b1;
                            r_state     <= ST_OVER;
                        end else begin
                            r_lives <= r_lives - 2'd1;
                            r_state <= ST_SERVE;
                        end
                    end else begin
                        r_miss_cnt <= r_miss_cnt + MC_W'(1);
                    end
                end
                default: begin
                    r_game_over <= 1'b1;
                end
            endcase
        end
    end

    assign ball_on   = w_on;
    assign rgb       = w_on ? BALL_RGB : 12'h000;
    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign score     = r_score;
    assign lives     = r_lives;
    assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_ball_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_controller
// Purpose  : Self-checking bench for ball_controller with a behavioural game
//            model, literal anchor points and randomized paddle play.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_controller;

    localparam int X_MIN = 144, X_MAX = 783, Y_MIN = 35, Y_MAX = 515;
    localparam int BALL_HALF = 4, PAD_HALF_W = 25, PAD_HALF_H = 5, STEP = 2;
    localparam int FRAME_DIV = 1, MISS_FRAMES = 60, LIVES_INIT = 3;
    localparam int S_SERVE = 0, S_MOVE = 1, S_MISS = 2, S_OVER = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bright = 1'b0;
    logic        launch = 1'b0;
    logic [9:0]  hCount = 10'd5, vCount = 10'd5;
    logic [9:0]  paddle_x = 10'd450, paddle_y = 10'd500;
    logic        ball_on, game_over;
    logic [11:0] rgb;
    logic [9:0]  ball_x, ball_y;
    logic [7:0]  score;
    logic [1:0]  lives;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model of the game
    int m_st = S_SERVE, m_x = 463, m_y = 465, m_dx = STEP, m_dy = -STEP;
    int m_score = 0, m_lives = LIVES_INIT, m_go = 0, m_mcnt = 0, m_fcnt = 0;
    bit m_strobe = 1'b0;

    ball_controller dut (
        .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
        .paddle_x(paddle_x), .paddle_y(paddle_y), .launch(launch),
        .ball_on(ball_on), .rgb(rgb), .ball_x(ball_x), .ball_y(ball_y),
        .score(score), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_SERVE; m_x = 463; m_y = Y_MAX - 40 - PAD_HALF_H - BALL_HALF - 1;
        m_dx = STEP; m_dy = -STEP; m_score = 0; m_lives = LIVES_INIT; m_go = 0;
        m_mcnt = 0; m_fcnt = 0; m_strobe = 1'b0;
    endtask

    task automatic model_update();
        int px, py, nx, ny, ndx, ndy, face, mag;
        bit hit;
        px = int'(paddle_x);
        py = int'(paddle_y);
        face = py - PAD_HALF_H;
        case (m_st)
            S_SERVE: begin
                m_x = clampi(px, X_MIN + BALL_HALF, X_MAX - BALL_HALF);
                m_y = clampi(face - BALL_HALF - 1, Y_MIN + BALL_HALF, Y_MAX - BALL_HALF);
                if (launch) begin m_st = S_MOVE; m_dx = STEP; m_dy = -STEP; end
            end
            S_MOVE: begin
                nx = m_x + m_dx; ny = m_y + m_dy; ndx = m_dx; ndy = m_dy;
                if (nx - BALL_HALF <= X_MIN)      begin ndx = -m_dx; nx = X_MIN + BALL_HALF; end
                else if (nx + BALL_HALF >= X_MAX) begin ndx = -m_dx; nx = X_MAX - BALL_HALF; end
                if (ny - BALL_HALF <= Y_MIN) begin ndy = -m_dy; ny = Y_MIN + BALL_HALF; end
                hit = (m_dy > 0) && (ny + BALL_HALF >= face) && (m_y + BALL_HALF < face)
                      && (iabs(nx - px) <= PAD_HALF_W + BALL_HALF);
                if (hit) begin
                    ndy = -STEP;
                    ny  = clampi(face - BALL_HALF - 1, Y_MIN + BALL_HALF, Y_MAX - BALL_HALF);
                    if (m_score < 255) m_score++;
`ifdef BALL_ANGLE_EN
                    mag = (iabs(nx - px) > PAD_HALF_W / 2) ? 2 * STEP : STEP;
                    ndx = (ndx < 0) ? -mag : mag;
`endif
                end else if (ny + BALL_HALF >= Y_MAX) begin
                    ny = Y_MAX - BALL_HALF;
                    m_st = S_MISS;
                    m_mcnt = 0;
                end
                m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
            end
            S_MISS: begin
                m_mcnt++;
                if (m_mcnt == MISS_FRAMES) begin
                    m_mcnt = 0;
                    if (m_lives == 1) begin m_lives = 0; m_go = 1; m_st = S_OVER; end
                    else begin m_lives--; m_st = S_SERVE; end
                end
            end
            default: ;
        endcase
    endtask

    // Model advances on the same edges as the design.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                if (m_strobe) begin
                    m_fcnt++;
                    if (m_fcnt == FRAME_DIV) begin m_fcnt = 0; model_update(); end
                end
                m_strobe = (hCount == 10'd0) && (vCount == 10'd0);
            end
        end
    end

    // Every-cycle comparison, sampled mid-low-phase.
    initial begin
        bit exp_on;
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                exp_on = bright && (iabs(int'(hCount) - m_x) <= BALL_HALF)
                                && (iabs(int'(vCount) - m_y) <= BALL_HALF);
                chk("ball_x",    int'(ball_x),    m_x);
                chk("ball_y",    int'(ball_y),    m_y);
                chk("score",     int'(score),     m_score);
                chk("lives",     int'(lives),     m_lives);
                chk("game_over", int'(game_over), m_go);
                chk("ball_on",   int'(ball_on),   int'(exp_on));
                chk("rgb",       int'(rgb),       exp_on ? 15 : 0);
            end
        end
    end

    task automatic rand_raster();
        int h, v;
        if ($urandom_range(0, 1) == 1) begin
            h = m_x + int'($urandom_range(0, 12)) - 6;
            v = m_y + int'($urandom_range(0, 12)) - 6;
        end else begin
            h = int'($urandom_range(1, 799));
            v = int'($urandom_range(0, 524));
        end
        hCount = 10'(h);
        vCount = 10'(v);
        bright = ($urandom_range(0, 7) != 0);
    endtask

    // One frame: raster origin, two ordinary pixels; the update lands on the second.
    task automatic upd(input int px, input int py, input bit ln);
        @(negedge clk);
        hCount = 10'd0; vCount = 10'd0;
        paddle_x = 10'(clampi(px, 0, 1023));
        paddle_y = 10'(clampi(py, 0, 1023));
        launch = ln;
        bright = 1'($urandom_range(0, 1));
        repeat (2) begin @(negedge clk); rand_raster(); end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        #900000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        int guard, py;
        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ball_x", int'(ball_x), 463);
        chk("rst_ball_y", int'(ball_y), 465);
        chk("rst_score",  int'(score), 0);
        chk("rst_lives",  int'(lives), 3);
        chk("rst_over",   int'(game_over), 0);
        chk("rst_ball_on_dark", int'(ball_on), 0);

        // Serve follows the paddle, launch starts the ball moving up-right
        upd(450, 500, 0); upd(450, 500, 0);
        chk("serve_x", int'(ball_x), 450);
        chk("serve_y", int'(ball_y), 490);
        upd(450, 500, 1);
        chk("launch_x", int'(ball_x), 450);
        upd(450, 500, 0);
        chk("move1_x", int'(ball_x), 452);
        chk("move1_y", int'(ball_y), 488);
        repeat (163) upd(450, 500, 0);
        upd(450, 500, 0);
        chk("rwall_clamp_x", int'(ball_x), 779);
        upd(450, 500, 0);
        chk("rwall_back_x", int'(ball_x), 777);
        chk("rwall_back_y", int'(ball_y), 158);
        repeat (60) upd(450, 500, 0);
        chk("top_x", int'(ball_x), 657);
        chk("top_y", int'(ball_y), 39);
        repeat (236) upd(450, 500, 0);
        chk("miss_x", int'(ball_x), 185);
        chk("miss_y", int'(ball_y), 511);
        chk("miss_lives", int'(lives), 3);
        repeat (59) upd(450, 500, 0);
        chk("miss_hold_lives", int'(lives), 3);
        upd(450, 500, 0);
        chk("miss_done_lives", int'(lives), 2);
        for (int l = 2; l >= 1; l--) begin
            upd(450, 500, 1);
            repeat (462) upd(450, 500, 0);
            chk("miss_again_y", int'(ball_y), 511);
            repeat (60) upd(450, 500, 0);
            chk("lives_left", int'(lives), l - 1);
        end
        chk("over_flag", int'(game_over), 1);
        repeat (10) begin
            upd(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            chk("over_frozen_x", int'(ball_x), 185);
            chk("over_frozen_y", int'(ball_y), 511);
            chk("over_lives", int'(lives), 0);
        end

        // Paddle near the top: short rallies drive the score to saturation
        do_reset();
        upd(450, 60, 0);
        chk("hiserve_y", int'(ball_y), 50);
        upd(450, 60, 1);
        repeat (11) upd(m_x, 60, 0);
        chk("prehit_x", int'(ball_x), 472);
        chk("prehit_y", int'(ball_y), 49);
        chk("prehit_score", int'(score), 0);
        upd(m_x, 60, 0);
        chk("hit_x", int'(ball_x), 474);
        chk("hit_y", int'(ball_y), 50);
        chk("hit_score", int'(score), 1);
        guard = 0;
        while (m_score < 255 && guard < 5000) begin
            upd(m_x + int'($urandom_range(0, 40)) - 20, 60, 0);
            guard++;
        end
        chk("score_reach_255", int'(score), 255);
        repeat (100) upd(m_x + int'($urandom_range(0, 40)) - 20, 60, 0);
        chk("score_sat", int'(score), 255);

        // Asynchronous reset mid-rally
        @(negedge clk);
        bright = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_ball_x", int'(ball_x), 463);
        chk("arst_ball_y", int'(ball_y), 465);
        chk("arst_score",  int'(score), 0);
        chk("arst_lives",  int'(lives), 3);
        chk("arst_over",   int'(game_over), 0);
        chk("arst_ball_on", int'(ball_on), 0);
        chk("arst_rgb",    int'(rgb), 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized play against the model
        for (int r = 0; r < 5; r++) begin
            do_reset();
            py = (r == 4) ? int'($urandom_range(0, 1023)) : int'($urandom_range(430, 510));
            repeat (1200) begin
                if ($urandom_range(0, 99) == 0) py = int'($urandom_range(40, 520));
                if ($urandom_range(0, 9) < 7)
                    upd(m_x + int'($urandom_range(0, 90)) - 45, py, ($urandom_range(0, 4) == 0));
                else
                    upd(int'($urandom_range(0, 1023)), py, ($urandom_range(0, 4) == 0));
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
